// File: rtl/axi_word_writer.sv
// Drains a DATA_WIDTH-wide FIFO and writes each word to a circular DDR region
// as a single-beat AXI4 write. Build with AXI_WR_RETRY_EN to retry failed writes.
module axi_word_writer #(
    parameter int                    DATA_WIDTH   = 256,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    REGION_WORDS = 1024,
    parameter int                    MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_data,
    output logic                    fifo_ren,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic [31:0]             words_written,
    output logic [15:0]             err_count
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int OFF_W    = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(REGION_WORDS - 1);

    // Catch unusable configurations at elaboration rather than in silicon.
    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || MAX_RETRY < 0 ||
        REGION_WORDS < 1 || (BASE_ADDR % BYTES) != 0) begin : g_bad_param
        $error("axi_word_writer: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_XFER, S_RESP} state_t;

    state_t                r_state, w_nxt;
    logic                  r_aw_done, r_w_done;
    logic [OFF_W-1:0]      r_offset;
    logic [OFF_W-1:0]      w_off_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [31:0]           r_words;
    logic [15:0]           r_errs;
    logic                  w_aw_hs, w_w_hs, w_b_ok, w_retry;

`ifdef AXI_WR_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] r_retry;
    assign w_retry = !w_b_ok && (r_retry < RETRY_W'(MAX_RETRY));
`else
    assign w_retry = 1'b0;
`endif

    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    assign w_b_ok    = (bresp == 2'b00);
    assign w_off_nxt = (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable && !fifo_empty) w_nxt = S_FETCH;
            S_FETCH: w_nxt = S_XFER;
            S_XFER:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_nxt = S_RESP;
            S_RESP:  if (bvalid) w_nxt = w_retry ? S_XFER : S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // rst_n gating keeps the FIFO from being popped while held in reset.
    always_comb begin
        fifo_ren = rst_n && (r_state == S_IDLE) && enable && !fifo_empty;
        awvalid  = (r_state == S_XFER) && !r_aw_done;
        wvalid   = (r_state == S_XFER) && !r_w_done;
        bready   = (r_state == S_RESP);
        busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_offset  <= '0;
            r_awaddr  <= BASE_ADDR;
            r_wdata   <= '0;
            r_words   <= '0;
            r_errs    <= '0;
`ifdef AXI_WR_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_wdata   <= fifo_data;
                    r_awaddr  <= BASE_ADDR + (ADDR_WIDTH'(r_offset) << SIZE_LOG);
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                S_XFER: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                S_RESP: if (bvalid) begin
                    if (w_b_ok) begin
                        r_words  <= r_words + 32'd1;
                        r_offset <= w_off_nxt;
`ifdef AXI_WR_RETRY_EN
                        r_retry  <= '0;
`endif
                    end else if (w_retry) begin
                        // Reissue the same address/data; no FIFO read, no pointer move.
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
`ifdef AXI_WR_RETRY_EN
                        r_retry   <= r_retry + 1'b1;
`endif
                    end else begin
                        if (r_errs != 16'hFFFF) r_errs <= r_errs + 16'd1;
                        r_offset <= w_off_nxt;
`ifdef AXI_WR_RETRY_EN
                        r_retry  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign awaddr        = r_awaddr;
    assign wdata         = r_wdata;
    assign awlen         = 8'd0;
    assign awsize        = 3'(SIZE_LOG);
    assign awburst       = 2'b01;
    assign wstrb         = '1;
    assign wlast         = 1'b1;
    assign words_written = r_words;
    assign err_count     = r_errs;
endmodule

// File: tb/tb_axi_word_writer.sv
// Directed bench for axi_word_writer: FIFO model, AXI slave with ready delays
// and a scripted B-response table, scoreboard checks on every AW/W handshake.
module tb_axi_word_writer;
    localparam int DW = 256;
    localparam int AW = 32;
    localparam logic [AW-1:0] BASE = 32'h0000_0000;
    localparam int REGION = 4;

    logic          clk = 1'b0;
    logic          rst_n, enable, fifo_empty, fifo_ren;
    logic [DW-1:0] fifo_data;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst, bresp;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready, busy;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic [31:0]   words_written;
    logic [15:0]   err_count;

    axi_word_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
                      .REGION_WORDS(REGION), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_ren(fifo_ren), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy),
        .words_written(words_written), .err_count(err_count));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0, ren_cnt = 0;
    logic b_en = 1'b1;
    logic [5:0] b_idx = '0;
    logic [1:0] bresp_tab [0:63];
    logic [DW-1:0] fifo_q [$];
    logic [AW-1:0] exp_aw [$];
    logic [DW-1:0] exp_w [$];
    int model_off = 0, exp_ww = 0, exp_err = 0;
    logic w_first = 1'b0;
    logic p_awv = 1'b0, p_wv = 1'b0, p_awhs = 1'b0, p_whs = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave: readies after a programmable number of valid cycles, B tied to bready.
    assign awready = (aw_wait >= aw_dly);
    assign wready  = (w_wait >= w_dly);
    assign bvalid  = bready && b_en;
    assign bresp   = bresp_tab[b_idx];

    always @(posedge clk) begin
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
        if (bvalid && bready) b_idx <= b_idx + 6'd1;
        if (fifo_ren) begin
            ren_cnt <= ren_cnt + 1;
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        fifo_empty <= (fifo_q.size() == 0);
        if (fifo_ren && fifo_q.size() == 0) chk("ren_while_empty", 1'b1, 1'b0);
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
            else chk("aw_addr", awaddr, exp_aw.pop_front());
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
            else chk("w_data", wdata, exp_w.pop_front());
        end
        if (awvalid && p_awv && !p_awhs) chk("aw_stable", awaddr, p_addr);
        if (wvalid && p_wv && !p_whs) chk("w_stable", wdata, p_data);
        if (awvalid && !wvalid) w_first <= 1'b1;
        p_awv <= awvalid; p_wv <= wvalid; p_addr <= awaddr; p_data <= wdata;
        p_awhs <= awvalid && awready; p_whs <= wvalid && wready;
    end

    task automatic push_word(input logic [DW-1:0] d, input int attempts);
        fifo_q.push_back(d);
        for (int i = 0; i < attempts; i++) begin
            exp_aw.push_back(BASE + AW'(model_off * (DW / 8)));
            exp_w.push_back(d);
        end
        model_off = (model_off + 1) % REGION;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(fifo_q.size() == 0 && !busy && exp_aw.size() == 0 && exp_w.size() == 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_off = 0; exp_ww = 0; exp_err = 0;
    endtask

    initial begin
        int ren0, n;
        for (int i = 0; i < 64; i++) bresp_tab[i] = 2'b00;
        rst_n = 1'b0; enable = 1'b0; fifo_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_fifo_ren", fifo_ren, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_words", words_written, 0);
        chk("rst_errs", err_count, 0);
        chk("rst_awaddr", awaddr, BASE);
        chk("awlen", awlen, 0);
        chk("awsize", awsize, 5);
        chk("awburst", awburst, 1);
        chk("wstrb", wstrb, {32{1'b1}});
        chk("wlast", wlast, 1);
        rst_n = 1'b1; enable = 1'b1;

        // Single word, all readies high.
        ren0 = ren_cnt;
        push_word({32{8'hA5}}, 1); exp_ww++;
        wait_drain(50, "t1_timeout");
        chk("t1_ren_pulses", ren_cnt - ren0, 1);
        chk("t1_words", words_written, exp_ww);
        chk("t1_wdata_held", wdata, {32{8'hA5}});
        chk("t1_busy", busy, 0);

        // Three words, awready delayed: W completes first.
        do_reset();
        aw_dly = 3; w_first = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word({8{32'hC0DE_0000 + i}}, 1); exp_ww++;
        end
        wait_drain(100, "t2_timeout");
        chk("t2_words", words_written, exp_ww);
        chk("t2_w_before_aw", w_first, 1);
        aw_dly = 0;

        // Region wrap: 6 words into a 4-word region.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_word({8{32'h5EED_0000 + i}}, 1); exp_ww++;
        end
        wait_drain(200, "t3_timeout");
        chk("t3_words", words_written, exp_ww);

        // Enable dropped during XFER.
        do_reset();
        push_word({8{32'hD00D_0001}}, 1);
        push_word({8{32'hD00D_0002}}, 1);
        ren0 = ren_cnt; n = 0;
        while (!awvalid && n < 20) begin @(negedge clk); n++; end
        chk("t4_reach_xfer", n < 20, 1);
        enable = 1'b0;
        n = 0;
        while (words_written != 32'd1 && n < 20) begin @(negedge clk); n++; end
        chk("t4_word_done", words_written, 1);
        repeat (8) @(negedge clk);
        chk("t4_no_ren", ren_cnt - ren0, 1);
        chk("t4_fifo_left", fifo_q.size(), 1);
        chk("t4_idle", busy, 0);
        enable = 1'b1; exp_ww = 2;
        wait_drain(50, "t4_timeout");
        chk("t4_words", words_written, exp_ww);

        // SLVERR then OKAY.
        do_reset();
        bresp_tab[b_idx] = 2'b10;
`ifdef AXI_WR_RETRY_EN
        push_word({8{32'hBAD0_0001}}, 2); exp_ww++;
`else
        push_word({8{32'hBAD0_0001}}, 1); exp_err++;
`endif
        push_word({8{32'hBAD0_0002}}, 1); exp_ww++;
        wait_drain(100, "t5_timeout");
        chk("t5_words", words_written, exp_ww);
        chk("t5_errs", err_count, exp_err);

        // Asynchronous reset while waiting in RESP.
        b_en = 1'b0;
        push_word({8{32'h7E57_0001}}, 1);
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        chk("t6_reach_resp", bready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_bready", bready, 0);
        chk("t6_awaddr", awaddr, BASE);
        chk("t6_wdata", wdata, 0);
        chk("t6_words", words_written, 0);
        chk("t6_errs", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1; b_en = 1'b1;
        model_off = 0; exp_ww = 0; exp_err = 0;
        push_word({8{32'h7E57_0002}}, 1); exp_ww++;
        wait_drain(50, "t6_timeout");
        chk("t6_after_words", words_written, exp_ww);
        chk("sb_aw_empty", exp_aw.size(), 0);
        chk("sb_w_empty", exp_w.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
